// File: rtl/pipeline_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : pipeline_pkg
// Brief  : Shared widths, bundle bit positions and datapath helper for the
//          pipeline units.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
package pipeline_pkg;

   localparam int PKG_DATA_W = 32;

   // Bit positions when flush/valid/stall travel as one bundled vector
   localparam int FLUSH_BIT = 2;
   localparam int VALID_BIT = 1;
   localparam int STALL_BIT = 0;
   localparam int CTRL_W    = 3;

   localparam int PERF_W = 16;

   function automatic logic [PKG_DATA_W-1:0] add_xor(
      input logic [PKG_DATA_W-1:0] data,
      input logic [PKG_DATA_W-1:0] add,
      input logic [PKG_DATA_W-1:0] mask
   );
      return (data + add) ^ mask;
   endfunction

endpackage : pipeline_pkg
`default_nettype wire

// File: rtl/stage_skid_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : stage_skid_fifo
// Brief  : Pointer-based skid FIFO with occupancy counter; dout is the head.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module stage_skid_fifo #(
   parameter int DEPTH  = 2,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic [DATA_W-1:0] din,
   input  logic              enq,
   input  logic              deq,
   output logic [DATA_W-1:0] dout,
   output logic              empty,
   output logic              full
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic              do_enq;
   logic              do_deq;

   assign empty  = (count == '0);
   assign full   = (count == FULL_CNT);
   assign do_enq = enq && !full;
   assign do_deq = deq && !empty;
   assign dout   = mem[rd_ptr];

   // Storage carries no reset; only pointers and count define contents
   always_ff @(posedge clk) begin
      if (do_enq) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_enq) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_deq) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_enq, do_deq})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule : stage_skid_fifo
`default_nettype wire

// File: rtl/pipeline_units_4_to_6.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : pipeline_units_4_to_6
// Brief  : Skid FIFO feeding an add stage then an xor stage, valid/flush/stall
//          protocol; PIPELINE_UNITS_4_TO_6_PERF_EN adds perf counters.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module pipeline_units_4_to_6
   import pipeline_pkg::*;
#(
   parameter int                DATA_W    = PKG_DATA_W,
   parameter int                DEPTH     = 2,
   parameter logic [DATA_W-1:0] ADD_CONST = DATA_W'(1),
   parameter logic [DATA_W-1:0] XOR_MASK  = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_flush,
   input  logic [DATA_W-1:0] inputs,
   input  logic              in_valid,
   input  logic              in_stall,
   output logic [DATA_W-1:0] outputs,
   output logic              out_valid,
   output logic              out_flush,
   output logic              out_stall
`ifdef PIPELINE_UNITS_4_TO_6_PERF_EN
   ,
   output logic [PERF_W-1:0] perf_accepted,
   output logic [PERF_W-1:0] perf_stalled
`endif
);

   logic              fifo_empty;
   logic              fifo_full;
   logic [DATA_W-1:0] fifo_dout;
   logic              enq;
   logic              deq;
   logic              a_ready;
   logic              b_ready;
   logic              valid_a;
   logic [DATA_W-1:0] data_a;
   logic [DATA_W-1:0] src;
   logic [DATA_W-1:0] sum_a;
   logic [DATA_W-1:0] mix_b;

   assign b_ready   = !(out_valid && in_stall);
   assign a_ready   = !valid_a || b_ready;
   assign enq       = in_valid && !fifo_full && !(fifo_empty && a_ready);
   assign deq       = !fifo_empty && a_ready;
   assign src       = fifo_empty ? inputs : fifo_dout;
   // Registered FIFO state only: no combinational path from in_stall
   assign out_stall = fifo_full;

   stage_skid_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (in_flush),
      .din   (inputs),
      .enq   (enq),
      .deq   (deq),
      .dout  (fifo_dout),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   generate
      if (DATA_W == PKG_DATA_W) begin : g_pkg_datapath
         assign sum_a = add_xor(src, ADD_CONST, '0);
         assign mix_b = add_xor(data_a, '0, XOR_MASK);
      end else begin : g_local_datapath
         assign sum_a = src + ADD_CONST;
         assign mix_b = data_a ^ XOR_MASK;
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_a   <= 1'b0;
         data_a    <= '0;
         out_valid <= 1'b0;
         outputs   <= '0;
         out_flush <= 1'b0;
      end else if (in_flush) begin
         valid_a   <= 1'b0;
         data_a    <= '0;
         out_valid <= 1'b0;
         outputs   <= '0;
         out_flush <= 1'b1;
      end else begin
         out_flush <= 1'b0;
         if (a_ready) begin
            valid_a <= fifo_empty ? in_valid : 1'b1;
            data_a  <= sum_a;
         end
         if (b_ready) begin
            out_valid <= valid_a;
            if (valid_a) begin
               outputs <= mix_b;
            end
         end
      end
   end

`ifdef PIPELINE_UNITS_4_TO_6_PERF_EN
   localparam logic [PERF_W-1:0] PERF_MAX = '1;

   logic accept_now;
   assign accept_now = in_valid && !out_stall && !in_flush;

   // Counters survive flush; only reset clears them
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_accepted <= '0;
         perf_stalled  <= '0;
      end else begin
         if (accept_now && (perf_accepted != PERF_MAX)) begin
            perf_accepted <= perf_accepted + 1'b1;
         end
         if (out_stall && (perf_stalled != PERF_MAX)) begin
            perf_stalled <= perf_stalled + 1'b1;
         end
      end
   end
`endif

endmodule : pipeline_units_4_to_6
`default_nettype wire

// File: tb/tb_pipeline_units_4_to_6.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_pipeline_units_4_to_6
// Brief  : Directed self-checking bench for pipeline_units_4_to_6.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_pipeline_units_4_to_6;

   logic        clk;
   logic        reset;
   logic        in_flush;
   logic [31:0] inputs;
   logic        in_valid;
   logic        in_stall;
   logic [31:0] outputs;
   logic        out_valid;
   logic        out_flush;
   logic        out_stall;
`ifdef PIPELINE_UNITS_4_TO_6_PERF_EN
   logic [15:0] perf_accepted;
   logic [15:0] perf_stalled;
`endif

   int checks = 0;
   int errors = 0;

   pipeline_units_4_to_6 dut (
      .clk       (clk),
      .reset     (reset),
      .in_flush  (in_flush),
      .inputs    (inputs),
      .in_valid  (in_valid),
      .in_stall  (in_stall),
      .outputs   (outputs),
      .out_valid (out_valid),
      .out_flush (out_flush),
      .out_stall (out_stall)
`ifdef PIPELINE_UNITS_4_TO_6_PERF_EN
      ,
      .perf_accepted (perf_accepted),
      .perf_stalled  (perf_stalled)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_ctl(input string tag, input logic v, input logic f, input logic s,
                          input logic [31:0] d);
      chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, v});
      chk({tag, ".out_flush"}, {31'd0, out_flush}, {31'd0, f});
      chk({tag, ".out_stall"}, {31'd0, out_stall}, {31'd0, s});
      chk({tag, ".outputs"}, outputs, d);
   endtask

   initial begin
      reset    = 1'b1;
      in_flush = 1'b0;
      inputs   = '0;
      in_valid = 1'b0;
      in_stall = 1'b0;
      #7;
      chk_ctl("reset", 1'b0, 1'b0, 1'b0, 32'd0);
      #1 reset = 1'b0;

      // Streaming: 10,11,12 -> 11,12,13
      in_valid = 1'b1; inputs = 32'd10;
      tick();
      chk("stream.lat1.out_valid", {31'd0, out_valid}, 32'd0);
      inputs = 32'd11;
      tick(); chk_ctl("stream.0", 1'b1, 1'b0, 1'b0, 32'd11);
      inputs = 32'd12;
      tick(); chk_ctl("stream.1", 1'b1, 1'b0, 1'b0, 32'd12);
      in_valid = 1'b0;
      tick(); chk_ctl("stream.2", 1'b1, 1'b0, 1'b0, 32'd13);
      tick(); chk("stream.drain.out_valid", {31'd0, out_valid}, 32'd0);

      // Full stall from a fresh reset, upstream holds 5 while stalled
      #2 reset = 1'b1;
      #1 reset = 1'b0;
      in_stall = 1'b1; in_valid = 1'b1; inputs = 32'd1;
      tick(); inputs = 32'd2;
      tick(); chk_ctl("stall.first", 1'b1, 1'b0, 1'b0, 32'd2);
      inputs = 32'd3;
      tick(); chk("stall.fill1.out_stall", {31'd0, out_stall}, 32'd0);
      inputs = 32'd4;
      tick(); chk_ctl("stall.full", 1'b1, 1'b0, 1'b1, 32'd2);
      inputs = 32'd5;
      tick(); chk_ctl("stall.hold", 1'b1, 1'b0, 1'b1, 32'd2);
      tick(); chk_ctl("stall.hold2", 1'b1, 1'b0, 1'b1, 32'd2);
      in_stall = 1'b0;
      tick(); chk_ctl("stall.rel0", 1'b1, 1'b0, 1'b0, 32'd3);
      tick(); chk_ctl("stall.rel1", 1'b1, 1'b0, 1'b0, 32'd4);
      inputs = 32'd6;
      tick(); chk_ctl("stall.rel2", 1'b1, 1'b0, 1'b0, 32'd5);
      in_valid = 1'b0;
      tick(); chk_ctl("stall.rel3", 1'b1, 1'b0, 1'b0, 32'd6);
      tick(); chk_ctl("stall.rel4", 1'b1, 1'b0, 1'b0, 32'd7);
      tick(); chk("stall.drain.out_valid", {31'd0, out_valid}, 32'd0);
`ifdef PIPELINE_UNITS_4_TO_6_PERF_EN
      chk("perf.accepted", {16'd0, perf_accepted}, 32'd6);
      chk("perf.stalled", {16'd0, perf_stalled}, 32'd3);
`endif

      // Idle flush: counters must survive it
      in_flush = 1'b1;
      tick(); chk_ctl("flush_idle", 1'b0, 1'b1, 1'b0, 32'd0);
      in_flush = 1'b0;
      tick(); chk("flush_idle.clear", {31'd0, out_flush}, 32'd0);
`ifdef PIPELINE_UNITS_4_TO_6_PERF_EN
      chk("perf.accepted.after_flush", {16'd0, perf_accepted}, 32'd6);
      chk("perf.stalled.after_flush", {16'd0, perf_stalled}, 32'd3);
`endif

      // Flush with three items in flight (B, A, one FIFO entry)
      in_stall = 1'b1; in_valid = 1'b1; inputs = 32'd20;
      tick(); inputs = 32'd21;
      tick(); inputs = 32'd22;
      tick(); chk_ctl("flush.pre", 1'b1, 1'b0, 1'b0, 32'd21);
      in_flush = 1'b1; inputs = 32'd99;
      tick(); chk_ctl("flush.hit", 1'b0, 1'b1, 1'b0, 32'd0);
      in_flush = 1'b0; in_stall = 1'b0; inputs = 32'd100;
      tick(); chk_ctl("flush.next", 1'b0, 1'b0, 1'b0, 32'd0);
      in_valid = 1'b0;
      tick(); chk_ctl("flush.resume", 1'b1, 1'b0, 1'b0, 32'd101);
      tick(); chk("flush.nostale.out_valid", {31'd0, out_valid}, 32'd0);

      // Simultaneous enq/deq with in_stall toggling
      in_valid = 1'b1; in_stall = 1'b1; inputs = 32'd30;
      tick(); inputs = 32'd31;
      tick(); chk_ctl("toggle.s2", 1'b1, 1'b0, 1'b0, 32'd31);
      inputs = 32'd32;
      tick(); chk_ctl("toggle.s3", 1'b1, 1'b0, 1'b0, 32'd31);
      inputs = 32'd33; in_stall = 1'b0;
      tick(); chk_ctl("toggle.s4", 1'b1, 1'b0, 1'b0, 32'd32);
      inputs = 32'd34; in_stall = 1'b1;
      tick(); chk_ctl("toggle.s5", 1'b1, 1'b0, 1'b1, 32'd32);
      inputs = 32'd35; in_stall = 1'b0;
      tick(); chk_ctl("toggle.s6", 1'b1, 1'b0, 1'b0, 32'd33);
      in_stall = 1'b1;
      tick(); chk_ctl("toggle.s7", 1'b1, 1'b0, 1'b1, 32'd33);
      inputs = 32'd36; in_stall = 1'b0;
      tick(); chk_ctl("toggle.s8", 1'b1, 1'b0, 1'b0, 32'd34);
      in_valid = 1'b0;
      tick(); chk_ctl("toggle.s9", 1'b1, 1'b0, 1'b0, 32'd35);
      tick(); chk_ctl("toggle.s10", 1'b1, 1'b0, 1'b0, 32'd36);
      tick(); chk("toggle.drain.out_valid", {31'd0, out_valid}, 32'd0);

      // Asynchronous reset while full and stalled
      in_valid = 1'b1; in_stall = 1'b1; inputs = 32'd1;
      tick(); inputs = 32'd2;
      tick(); inputs = 32'd3;
      tick(); inputs = 32'd4;
      tick(); chk("areset.pre.out_stall", {31'd0, out_stall}, 32'd1);
      #2 reset = 1'b1;
      #1 chk_ctl("areset.now", 1'b0, 1'b0, 1'b0, 32'd0);
`ifdef PIPELINE_UNITS_4_TO_6_PERF_EN
      chk("areset.perf_accepted", {16'd0, perf_accepted}, 32'd0);
`endif
      #3 reset = 1'b0;
      in_stall = 1'b0; inputs = 32'd50;
      tick(); in_valid = 1'b0;
      tick(); chk_ctl("areset.resume", 1'b1, 1'b0, 1'b0, 32'd51);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_pipeline_units_4_to_6
`default_nettype wire
